dmem_sram_pipe: RTL

// Parametrised single-port data SRAM for the ZeroRiscy data bus. It uses a req/gnt/rvalid handshake,
// per-byte write/read enables, a configurable read-latency pipeline and a self-clearing INIT sweep.
// It also has synthesizable read/write access counters that replace simulation-only profiling.
// It sits between the core LSU and the data address map, as the generalised next-generation DMEM.

---
 rtl/dmem_sram_pipe.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_sram_pipe.sv
// Single-port data SRAM for the ZeroRiscy data bus.
// The core side uses a req/gnt/rvalid handshake with per-byte enables. The response pipeline
// depth is configurable. After every reset, a sweep writes zero to the whole array.
// Saturating read and write access counters are included for profiling in hardware.
module dmem_sram_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 8192,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  err_o,
  output logic                  busy_o,
  input  logic                  cnt_clr_i,
  output logic [CNT_W-1:0]      rd_cnt_o,
  output logic [CNT_W-1:0]      wr_cnt_o
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);

  // Reject illegal configurations at elaboration time
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("dmem_sram_pipe: RD_LAT must be in 1..4");
  end
  if ((DATA_W % 8) != 0) begin : g_bad_data_w
    $error("dmem_sram_pipe: DATA_W must be a multiple of 8");
  end
  if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
    $error("dmem_sram_pipe: DEPTH must be in 1..2**ADDR_W");
  end

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;

  logic                in_range;
  logic                gnt;
  logic                wr_en;
  logic                rd_hit;
  logic                init_wr;
  logic [DATA_W-1:0]   be_mask;

  // ---------------------------------------------------------------------------
  // Request decode: grants are only issued in READY and never while reset is low
  // ---------------------------------------------------------------------------
  assign in_range = {1'b0, addr_i} < DEPTH_W;
  assign gnt      = (state_q == ST_READY) && req_i && HRESETn;
  assign wr_en    = gnt && we_i && in_range;
  assign rd_hit   = gnt && !we_i && in_range;
  assign init_wr  = (state_q == ST_INIT);

  // Expand the byte enables into a bit mask for read-data masking
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default first, so no latch is inferred.
    be_mask = '0;
    for (int b = 0; b < NB; b++) begin
      be_mask[8*b +: 8] = {8{be_i[b]}};
    end
  end

  // Sweep FSM next state: step the pointer through every word, then hand over to READY
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_INIT) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == LAST_PTR) begin
        state_d = ST_READY;
        ptr_d   = '0;
      end
    end
  end

  // Sweep FSM registers; a reset always restarts the clearing sweep
  always_ff @(posedge HCLK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!HRESETn) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array with byte-lane writes and a registered read port
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word_q;

  // Array write (sweep or granted write) and synchronous read capture
  always_ff @(posedge HCLK) begin
    // NOTE: the array has no reset branch, so it can map onto SRAM macros; the sweep FSM clears it instead.
    if (init_wr) begin
      mem[ptr_q] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) begin
          mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    if (rd_hit) begin
      rd_word_q <= mem[addr_i];
    end
  end

  // ---------------------------------------------------------------------------
  // Response stage 1: qualifiers that travel alongside the array read register
  // ---------------------------------------------------------------------------
  logic              s1_vld_q, s1_vld_d;
  logic              s1_err_q, s1_err_d;
  logic              s1_rd_q,  s1_rd_d;
  logic [DATA_W-1:0] s1_mask_q, s1_mask_d;
  logic [DATA_W-1:0] s1_data;

  // Stage 1 next state: each grant launches one response
  always_comb begin
    s1_vld_d  = gnt;
    s1_err_d  = gnt && !in_range;
    s1_rd_d   = rd_hit;
    s1_mask_d = be_mask;
  end

  // Stage 1 registers; reset drops any response in flight
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      s1_vld_q  <= 1'b0;
      s1_err_q  <= 1'b0;
      s1_rd_q   <= 1'b0;
      s1_mask_q <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_err_q  <= s1_err_d;
      s1_rd_q   <= s1_rd_d;
      s1_mask_q <= s1_mask_d;
    end
  end

  // Writes and out-of-range accesses return zero data; reads keep only enabled bytes
  assign s1_data = s1_rd_q ? (rd_word_q & s1_mask_q) : '0;

  // ---------------------------------------------------------------------------
  // Response stages 2..RD_LAT: plain delay registers
  // ---------------------------------------------------------------------------
  logic              out_vld;
  logic              out_err;
  logic [DATA_W-1:0] out_data;

  if (RD_LAT > 1) begin : g_dly
    logic [RD_LAT-2:0]             vld_q, vld_d;
    logic [RD_LAT-2:0]             err_q, err_d;
    logic [RD_LAT-2:0][DATA_W-1:0] dat_q, dat_d;

    // Shift the response one stage per cycle
    always_comb begin
      vld_d    = vld_q;
      err_d    = err_q;
      dat_d    = dat_q;
      vld_d[0] = s1_vld_q;
      err_d[0] = s1_err_q;
      dat_d[0] = s1_data;
      for (int i = 1; i < RD_LAT - 1; i++) begin
        vld_d[i] = vld_q[i-1];
        err_d[i] = err_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end

    // Delay registers; reset empties the whole pipeline
    always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
        vld_q <= '0;
        err_q <= '0;
        dat_q <= '0;
      end else begin
        vld_q <= vld_d;
        err_q <= err_d;
        dat_q <= dat_d;
      end
    end

    assign out_vld  = vld_q[RD_LAT-2];
    assign out_err  = err_q[RD_LAT-2];
    assign out_data = dat_q[RD_LAT-2];
  end else begin : g_no_dly
    assign out_vld  = s1_vld_q;
    assign out_err  = s1_err_q;
    assign out_data = s1_data;
  end

  // ---------------------------------------------------------------------------
  // Saturating access counters; a clear takes priority over a same-cycle increment
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

  // Counter next state
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (cnt_clr_i) begin
      rd_cnt_d = '0;
      wr_cnt_d = '0;
    end else begin
      if (gnt && !we_i && (rd_cnt_q != {CNT_W{1'b1}})) begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
      if (gnt && we_i && (wr_cnt_q != {CNT_W{1'b1}})) begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: responses are masked while reset is low, and data/err are zero without rvalid
  // ---------------------------------------------------------------------------
  assign gnt_o    = gnt;
  assign busy_o   = (state_q == ST_INIT) || !HRESETn;
  assign rvalid_o = out_vld && HRESETn;
  assign rdata_o  = rvalid_o ? out_data : '0;
  assign err_o    = rvalid_o && out_err;
  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;

endmodule
